// File: rtl/jtag_host_shifter.sv
// jtag_host_shifter
//   Host-side JTAG sequencer. It accepts one command at a time, generates
//   TCK/TMS/TDI and returns the TDO bits captured during SHIFT. Every
//   command starts and ends with the target TAP in Run-Test/Idle.
//   The commands are TAP reset, IR scan, DR scan and run-test idle.
//
//   Ports:
//     clk, rst_n        system clock; asynchronous active-low reset
//     cmd_valid/ready   command handshake. cmd_ready is high only in IDLE.
//     cmd_op            0=RESET 1=SCAN_IR 2=SCAN_DR 3=RUNTEST
//     cmd_len           scan bit count or RUNTEST TCK count.
//                       A value of 0 acts as 1. Values above MAX_LEN are
//                       clamped to MAX_LEN.
//     cmd_data          TDI bits, LSB shifted first
//     rsp_valid         one-clk pulse when a command completes
//     rsp_data          captured TDO bits, right-justified
//     busy              high from the cycle after acceptance through DONE
//     tck, tms, tdi     JTAG outputs to the target
//     tdo               JTAG input from the target
//     trst_n            optional TAP reset output. It exists only when
//                       JTAG_HOST_TRST_EN is defined.
//
//   Optional build macro: JTAG_HOST_TRST_EN
//     This macro adds trst_n. The signal is held low during a RESET
//     command, from acceptance to the end of the 5th TCK high phase.
module jtag_host_shifter #(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
`ifdef JTAG_HOST_TRST_EN
    output logic               trst_n,
`endif
    input  logic               tdo
);

    // One bit index register serves all phases. It must be able to count
    // the 6-bit RESET header, even when MAX_LEN is tiny.
    localparam int IW = (LEN_W > 3) ? LEN_W : 3;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, DONE} state_t;
    typedef enum logic [1:0] {OP_RESET, OP_SCAN_IR, OP_SCAN_DR, OP_RUNTEST} op_t;

    state_t             state;
    state_t             nxt_state;
    op_t                op_q;
    logic [IW-1:0]      len_q;
    logic [IW-1:0]      len_eff;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      nxt_idx;
    logic [IW-1:0]      pre_last;
    logic [5:0]         pre_pat;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] cap;
    logic [MAX_LEN-1:0] cap_mask;
    logic [MAX_LEN-1:0] sel_mask;
    logic [CW-1:0]      cnt;
    logic               nxt_tms;
    logic               nxt_tdi;

    always_comb begin
        if (cmd_len == '0) begin
            len_eff = IW'(1);
        end else if (cmd_len > LEN_W'(MAX_LEN)) begin
            len_eff = IW'(MAX_LEN);
        end else begin
            len_eff = IW'(cmd_len);
        end
    end

    // The header TMS pattern is listed LSB first. RESET runs entirely in
    // the header phase and ends with a 0 bit, which takes the TAP into
    // Run-Test/Idle.
    always_comb begin
        case (op_q)
            OP_RESET: begin
                pre_pat  = 6'b011111;
                pre_last = IW'(5);
            end
            OP_SCAN_IR: begin
                pre_pat  = 6'b000011;
                pre_last = IW'(3);
            end
            default: begin
                pre_pat  = 6'b000001;
                pre_last = IW'(2);
            end
        endcase
    end

    // This block computes the phase and index that follow the current TCK
    // bit. They take effect on the falling TCK edge.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx + IW'(1);
        case (state)
            PRE: begin
                if (idx == pre_last) begin
                    nxt_idx   = '0;
                    nxt_state = (op_q == OP_RESET) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (idx == len_q - IW'(1)) begin
                    nxt_idx   = '0;
                    nxt_state = (op_q == OP_RUNTEST) ? DONE : POST;
                end
            end
            POST: begin
                if (idx == IW'(1)) begin
                    nxt_idx   = '0;
                    nxt_state = DONE;
                end
            end
            default: nxt_idx = '0;
        endcase
    end

    assign sel_mask = MAX_LEN'(1) << nxt_idx;
    assign cap_mask = MAX_LEN'(1) << idx;

    // These are the TMS/TDI values for the next bit. They are loaded into
    // the output registers together with the falling TCK edge.
    always_comb begin
        nxt_tms = 1'b0;
        nxt_tdi = 1'b0;
        case (nxt_state)
            PRE: nxt_tms = pre_pat[nxt_idx[2:0]];
            SHIFT: begin
                if (op_q != OP_RUNTEST) begin
                    nxt_tms = (nxt_idx == len_q - IW'(1));
                    nxt_tdi = |(data_q & sel_mask);
                end
            end
            POST: nxt_tms = (nxt_idx == '0);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_RESET;
            len_q     <= '0;
            data_q    <= '0;
            cap       <= '0;
            idx       <= '0;
            cnt       <= '0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef JTAG_HOST_TRST_EN
            trst_n    <= 1'b1;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= op_t'(cmd_op);
                        len_q     <= len_eff;
                        data_q    <= cmd_data;
                        cap       <= '0;
                        idx       <= '0;
                        cnt       <= '0;
                        tck       <= 1'b0;
                        tdi       <= 1'b0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        if (op_t'(cmd_op) == OP_RUNTEST) begin
                            state <= SHIFT;
                            tms   <= 1'b0;
                        end else begin
                            state <= PRE;
                            tms   <= 1'b1;
                        end
`ifdef JTAG_HOST_TRST_EN
                        trst_n <= (op_t'(cmd_op) != OP_RESET);
`endif
                    end
                end
                PRE, SHIFT, POST: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (!tck) begin
                            // This edge raises TCK, so it also samples tdo.
                            tck <= 1'b1;
                            if (state == SHIFT && op_q != OP_RUNTEST && tdo) begin
                                cap <= cap | cap_mask;
                            end
                        end else begin
                            tck   <= 1'b0;
                            state <= nxt_state;
                            idx   <= nxt_idx;
                            tms   <= nxt_tms;
                            tdi   <= nxt_tdi;
`ifdef JTAG_HOST_TRST_EN
                            if (state == PRE && op_q == OP_RESET && idx == IW'(4)) begin
                                trst_n <= 1'b1;
                            end
`endif
                            if (nxt_state == DONE) begin
                                rsp_valid <= 1'b1;
                                rsp_data  <= cap;
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Testbench for jtag_host_shifter. It contains a behavioural TAP target,
// a reference command model and a scoreboard monitor.
`timescale 1ns/1ps
module tb_jtag_host_shifter;

    localparam int MAX_LEN  = 32;
    localparam int CLK_DIV  = 2;
    localparam int LEN_W    = $clog2(MAX_LEN + 1);
    localparam int BIT_CLKS = 2 * CLK_DIV;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [31:0]      cmd_data = '0;
    logic             cmd_ready;
    logic             rsp_valid;
    logic [31:0]      rsp_data;
    logic             busy;
    logic             tck;
    logic             tms;
    logic             tdi;
    logic             tdo = 1'b0;
`ifdef JTAG_HOST_TRST_EN
    logic             trst_n;
`endif

    jtag_host_shifter #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi),
`ifdef JTAG_HOST_TRST_EN
        .trst_n(trst_n),
`endif
        .tdo(tdo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // ---------------- behavioural TAP target ----------------
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPIR} tap_t;
    tap_t        tap_st = SHDR;
    logic [31:0] dr_cap = '0;
    logic [31:0] dr_sh = '0;
    logic [31:0] dr_upd = '0;
    logic [3:0]  ir_sh = '0;
    logic [3:0]  ir_upd = '0;
    localparam logic [3:0] IR_CAP = 4'b0001;

    always @(posedge tck) begin
        case (tap_st)
            CAPDR: dr_sh = dr_cap;
            SHDR:  dr_sh = {tdi, dr_sh[31:1]};
            UPDR:  dr_upd = dr_sh;
            CAPIR: ir_sh = IR_CAP;
            SHIR:  ir_sh = {tdi, ir_sh[3:1]};
            UPIR:  ir_upd = ir_sh;
            default: ;
        endcase
        case (tap_st)
            TLR:   tap_st = tms ? TLR   : RTI;
            RTI:   tap_st = tms ? SELDR : RTI;
            SELDR: tap_st = tms ? SELIR : CAPDR;
            CAPDR: tap_st = tms ? EX1DR : SHDR;
            SHDR:  tap_st = tms ? EX1DR : SHDR;
            EX1DR: tap_st = tms ? UPDR  : PSDR;
            PSDR:  tap_st = tms ? EX2DR : PSDR;
            EX2DR: tap_st = tms ? UPDR  : SHDR;
            UPDR:  tap_st = tms ? SELDR : RTI;
            SELIR: tap_st = tms ? TLR   : CAPIR;
            CAPIR: tap_st = tms ? EX1IR : SHIR;
            SHIR:  tap_st = tms ? EX1IR : SHIR;
            EX1IR: tap_st = tms ? UPIR  : PSIR;
            PSIR:  tap_st = tms ? EX2IR : PSIR;
            EX2IR: tap_st = tms ? UPIR  : SHIR;
            default: tap_st = tms ? SELDR : RTI;
        endcase
    end

    always @(negedge tck) begin
        tdo = (tap_st == SHDR) ? dr_sh[0] : (tap_st == SHIR) ? ir_sh[0] : 1'b0;
    end

    // ---------------- reference command model ----------------
    typedef struct {
        int          op;
        int          ntck;
        logic [63:0] tms;
        logic [63:0] tdi;
        logic [31:0] rsp;
        logic [31:0] upd;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(input int op, input int len, input logic [31:0] data,
                                   input logic [31:0] dcap);
        exp_t e;
        int eff;
        int n;
        int w;
        logic [31:0] cap;
        eff   = (len == 0) ? 1 : (len > MAX_LEN) ? MAX_LEN : len;
        e.op  = op;
        e.tms = '0;
        e.tdi = '0;
        e.rsp = '0;
        e.upd = '0;
        n = 0;
        if (op == 0) begin
            for (int i = 0; i < 6; i++) begin
                e.tms[n] = (i < 5);
                n++;
            end
        end else if (op == 3) begin
            n = eff;
        end else begin
            w   = (op == 1) ? 4 : 32;
            cap = (op == 1) ? 32'(IR_CAP) : dcap;
            e.tms[n] = 1'b1; n++;
            if (op == 1) begin
                e.tms[n] = 1'b1; n++;
            end
            n += 2;
            for (int i = 0; i < eff; i++) begin
                e.tms[n] = (i == eff - 1);
                e.tdi[n] = data[i];
                n++;
            end
            e.tms[n] = 1'b1;
            n += 2;
            for (int i = 0; i < eff; i++) begin
                if (i < w) e.rsp[i] = cap[i];
                else       e.rsp[i] = data[i - w];
            end
            for (int j = 0; j < w; j++) begin
                if (j + eff < w) e.upd[j] = cap[j + eff];
                else             e.upd[j] = data[j + eff - w];
            end
        end
        e.ntck = n;
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int          n_tck = 0;
    int          busy_cyc = 0;
    int          trst_low = 0;
    int          edge_viol = 0;
    logic [63:0] tms_acc = '0;
    logic [63:0] tdi_acc = '0;
    logic        prev_tck = 1'b0;
    logic        prev_tms = 1'b1;
    logic        prev_tdi = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            n_tck = 0; busy_cyc = 0; trst_low = 0;
            tms_acc = '0; tdi_acc = '0;
            prev_tck = 1'b0; prev_tms = 1'b1; prev_tdi = 1'b0;
        end else begin
            if (tck && (tms !== prev_tms || tdi !== prev_tdi)) edge_viol++;
            if (tck && !prev_tck && n_tck < 64) begin
                tms_acc[n_tck] = tms;
                tdi_acc[n_tck] = tdi;
                n_tck++;
            end
            if (busy) busy_cyc++;
`ifdef JTAG_HOST_TRST_EN
            if (!trst_n) trst_low++;
`endif
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_rsp: got rsp_valid with rsp_data=0x%0h, want no response", rsp_data);
                end else begin
                    e = sb.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(e.rsp));
                    check("tck_count", 64'(n_tck), 64'(e.ntck));
                    check("tms_seq", tms_acc, e.tms);
                    check("tdi_seq", tdi_acc, e.tdi);
                    check("busy_clks", 64'(busy_cyc), 64'(e.ntck * BIT_CLKS + 1));
                    check("done_pins", 64'({tck, tms, cmd_ready, busy}), 64'(4'b0001));
                    check("tap_in_rti", 64'(tap_st == RTI), 64'(1));
                    if (e.op == 1) check("ir_update", 64'(ir_upd), 64'(e.upd));
                    else if (e.op == 2) check("dr_update", 64'(dr_upd), 64'(e.upd));
`ifdef JTAG_HOST_TRST_EN
                    check("trst_low_clks", 64'(trst_low), 64'((e.op == 0) ? 5 * BIT_CLKS : 0));
                    check("trst_end", 64'(trst_n), 64'(1));
`endif
                end
                n_tck = 0; busy_cyc = 0; trst_low = 0;
                tms_acc = '0; tdi_acc = '0;
            end
            prev_tck = tck; prev_tms = tms; prev_tdi = tdi;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int op, input int len, input logic [31:0] data, input logic [31:0] cap);
        int t;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            timeout_fail("cmd_ready_wait");
            return;
        end
        dr_cap    = cap;
        cmd_op    = 2'(op);
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        cmd_valid = 1'b1;
        sb.push_back(model(op, len, data, cap));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [31:0] b_data;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rst_tck", 64'(tck), 64'(0));
        check("rst_tms", 64'(tms), 64'(1));
        check("rst_tdi", 64'(tdi), 64'(0));
        check("rst_ready", 64'(cmd_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp", 64'({rsp_valid, rsp_data}), 64'(0));
`ifdef JTAG_HOST_TRST_EN
        check("rst_trst", 64'(trst_n), 64'(1));
`endif

        send(0, 0, 32'hFFFF_FFFF, 32'h0);
        send(2, 8, 32'h0000_00A5, 32'h0000_003C);
        send(1, 4, 32'h0000_0001, $urandom);
        send(2, 0, $urandom, $urandom);
        send(2, 40, $urandom, $urandom);
        send(3, 3, 32'hFFFF_FFFF, $urandom);

        // cmd_valid stays high and the command inputs keep changing while a
        // scan runs. Only the command presented after DONE may be taken.
        send(3, 1, 32'h0, dr_cap);
        @(negedge clk);
        t = 0;
        while (!cmd_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        dr_cap    = $urandom;
        cmd_op    = 2'd2;
        cmd_len   = LEN_W'(12);
        cmd_data  = $urandom;
        cmd_valid = 1'b1;
        sb.push_back(model(2, 12, cmd_data, dr_cap));
        @(posedge clk);
        t = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid || t >= 500) break;
            cmd_op   = 2'($urandom);
            cmd_len  = LEN_W'($urandom_range(0, 40));
            cmd_data = $urandom;
            t++;
        end
        if (!rsp_valid) timeout_fail("hold_done");
        check("hold_ready_in_done", 64'(cmd_ready), 64'(0));
        b_data   = $urandom;
        cmd_op   = 2'd1;
        cmd_len  = LEN_W'(6);
        cmd_data = b_data;
        sb.push_back(model(1, 6, b_data, dr_cap));
        @(negedge clk);
        check("hold_ready_idle", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1 cmd_valid = 1'b0;

        for (int k = 0; k < 20; k++) begin
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)), $urandom, $urandom);
        end

        // Assert reset in the middle of the shift phase.
        send(2, 16, $urandom, $urandom);
        t = 0;
        while (n_tck < 6 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (n_tck < 6) timeout_fail("mid_shift_wait");
        #2 rst_n = 1'b0;
        #1;
        check("abort_tck", 64'(tck), 64'(0));
        check("abort_tms", 64'(tms), 64'(1));
        check("abort_outputs", 64'({rsp_valid, busy, cmd_ready, tdi}), 64'(4'b0010));
`ifdef JTAG_HOST_TRST_EN
        check("abort_trst", 64'(trst_n), 64'(1));
`endif
        if (sb.size() > 0) void'(sb.pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_rsp_data", 64'(rsp_data), 64'(0));

        send(0, 5, $urandom, $urandom);
        send(2, 12, $urandom, $urandom);
        send(1, 7, $urandom, $urandom);

        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) timeout_fail("final_drain");
        check("tms_tdi_stable_while_tck_high", 64'(edge_viol), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
